mips32_mem_responder: RTL and testbench

Memory-side responder for the MIPS32 pipeline's two memory interfaces: the instruction-fetch port (read-only) and the data port (LW/SW). Holds a single-ported DEPTH x 32 word-addressed array, arbitrates between the two request streams with data priority plus a fetch anti-starvation counter, and returns read data with fixed one-cycle latency. Sits between the core's IF/MEM stages and the storage array.

---
 rtl/mips32_mem_responder.sv | 91 +++++++++
 tb/tb_mips32_mem_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mips32_mem_responder.sv
// rtl/mips32_mem_responder.sv - MIPS32 fetch/data responder over a single-ported word array
// Optional build macro: MIPS32_MEMRESP_RANGE_CHECK_EN (out-of-range accesses return err, no array access)
module mips32_mem_responder #(
  parameter int DEPTH     = 1024,
  parameter int MAX_STALL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(MAX_STALL + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

  logic [31:0]   mem_q [DEPTH];
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic          if_rvalid_q, d_rvalid_q;
  logic          if_err_q, d_err_q;
  logic [31:0]   if_rdata_q, d_rdata_q;
  logic [31:0]   if_rdata_d, d_rdata_d;
  logic          if_oor, d_oor, fetch_forced;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;

`ifdef MIPS32_MEMRESP_RANGE_CHECK_EN
  assign if_oor = (if_addr >= 32'(DEPTH));
  assign d_oor  = (d_addr >= 32'(DEPTH));
`else
  logic unused_upper;
  assign if_oor       = 1'b0;
  assign d_oor        = 1'b0;
  assign unused_upper = ^{if_addr[31:AW], d_addr[31:AW]};
`endif

  // Data wins contention until fetch has been denied MAX_STALL times in a row.
  assign fetch_forced = (stall_cnt_q == STALL_MAX);
  assign if_gnt       = if_req & (~d_req | fetch_forced);
  assign d_gnt        = d_req & ~if_gnt;
  assign stall_cnt_d  = (if_req & d_req & ~fetch_forced) ? stall_cnt_q + SW'(1) : '0;

  assign rd_idx     = if_gnt ? if_addr[AW-1:0] : d_addr[AW-1:0];
  assign rd_word    = mem_q[rd_idx];
  assign if_rdata_d = (if_gnt & ~if_oor) ? rd_word : '0;
  assign d_rdata_d  = (d_gnt & ~d_we & ~d_oor) ? rd_word : '0;

  always_ff @(posedge clk) begin
    if (d_gnt && d_we && !d_oor) begin
      mem_q[d_addr[AW-1:0]] <= d_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if_rvalid_q <= if_gnt;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_gnt & if_oor;
      d_rvalid_q  <= d_gnt;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_gnt & d_oor;
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
endmodule

// File: tb/tb_mips32_mem_responder.sv
// tb/tb_mips32_mem_responder.sv - randomized scoreboard bench for mips32_mem_responder
module tb_mips32_mem_responder;
  localparam int DEPTH     = 1024;
  localparam int MAX_STALL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;

  mips32_mem_responder #(.DEPTH(DEPTH), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic err; int due; } resp_t;
  resp_t       if_q[$], d_q[$];
  logic [31:0] mdl [DEPTH];
  int          n_cmp = 0, n_bad = 0, cyc = 0;
  bit          if_pend, d_pend, d_w, g_if, g_d;
  logic [31:0] if_a, d_a, d_wd;
  int          denied;
  logic [11:0] mask;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic resp_t model_access(bit we, logic [31:0] addr, logic [31:0] wd, int due);
    resp_t r;
    int    idx = int'(addr % DEPTH);
    bit    oor;
`ifdef MIPS32_MEMRESP_RANGE_CHECK_EN
    oor = (addr >= DEPTH);
`else
    oor = 1'b0;
`endif
    r.due = due; r.err = oor; r.data = '0;
    if (!oor) begin
      if (we) mdl[idx] = wd;
      else    r.data = mdl[idx];
    end
    return r;
  endfunction

  // Mostly words 0..15, sometimes the same words with random upper address bits.
  function automatic logic [31:0] rand_addr();
    int          r   = $urandom_range(0, 9);
    logic [31:0] idx = $urandom_range(0, 15);
    if (r < 7) return idx;
    return ($urandom & ~32'(DEPTH - 1)) | idx;
  endfunction

  task automatic req_if(logic [31:0] a);
    if_pend = 1'b1; if_a = a;
  endtask

  task automatic req_d(bit we, logic [31:0] a, logic [31:0] wd);
    d_pend = 1'b1; d_w = we; d_a = a; d_wd = wd;
  endtask

  task automatic tick();
    bit gi, gd;
    @(negedge clk);
    if_req = if_pend; if_addr = if_a;
    d_req = d_pend; d_we = d_w; d_addr = d_a; d_wdata = d_wd;
    #2;
    gi = if_pend && (!d_pend || denied >= MAX_STALL);
    gd = d_pend && !gi;
    check("if_gnt", 32'(if_gnt), 32'(gi));
    check("d_gnt", 32'(d_gnt), 32'(gd));
    if (if_pend && d_pend) denied = gi ? 0 : denied + 1;
    else denied = 0;
    if (gi) begin if_q.push_back(model_access(1'b0, if_a, '0, cyc + 1)); if_pend = 1'b0; end
    if (gd) begin d_q.push_back(model_access(d_w, d_a, d_wd, cyc + 1)); d_pend = 1'b0; end
    g_if = gi; g_d = gd;
  endtask

  task automatic drain();
    int n = 0;
    while ((if_pend || d_pend) && n < 50) begin tick(); n++; end
    if (if_pend || d_pend) begin
      n_cmp++; n_bad++;
      $display("FAIL grant_timeout: got pending=%0d%0d expected 00", if_pend, d_pend);
    end
  endtask

  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (if_rvalid) begin
          if (if_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL if_unexpected: got if_rvalid=1 expected 0 (cycle %0d)", cyc);
          end else begin
            e = if_q.pop_front();
            check("if_latency", 32'(cyc), 32'(e.due));
            check("if_rdata", if_rdata, e.data);
            check("if_err", 32'(if_err), 32'(e.err));
          end
        end else if (if_q.size() > 0 && if_q[0].due <= cyc) begin
          e = if_q.pop_front();
          check("if_rvalid", 32'(if_rvalid), 32'(1));
        end
        if (d_rvalid) begin
          if (d_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL d_unexpected: got d_rvalid=1 expected 0 (cycle %0d)", cyc);
          end else begin
            e = d_q.pop_front();
            check("d_latency", 32'(cyc), 32'(e.due));
            check("d_rdata", d_rdata, e.data);
            check("d_err", 32'(d_err), 32'(e.err));
          end
        end else if (d_q.size() > 0 && d_q[0].due <= cyc) begin
          e = d_q.pop_front();
          check("d_rvalid", 32'(d_rvalid), 32'(1));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    if_pend = 1'b0; d_pend = 1'b0; d_w = 1'b0; if_a = '0; d_a = '0; d_wd = '0; denied = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_if_rvalid", 32'(if_rvalid), 32'(0));
    check("rst_d_rvalid", 32'(d_rvalid), 32'(0));
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_if_err", 32'(if_err), 32'(0));
    check("rst_d_err", 32'(d_err), 32'(0));
    rst_n = 1'b1;

    req_d(1'b1, 32'd5, 32'hDEADBEEF); tick();
    req_d(1'b0, 32'd5, '0); tick();
    tick();

    for (int i = 0; i < 16; i++) begin
      req_d(1'b1, 32'(i), (i < 4) ? 32'((i + 1) * 10) : $urandom);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      req_if(32'(i)); tick();
    end
    tick();

    req_d(1'b1, 32'd1030, 32'h1234); tick();
    req_d(1'b0, 32'd6, '0); tick();
    req_if(32'd6); tick();
    tick();

    mask = '0;
    for (int i = 0; i < 12; i++) begin
      if (!if_pend) req_if(rand_addr());
      if (!d_pend) req_d(1'($urandom % 2), rand_addr(), $urandom);
      tick();
      mask[i] = g_if;
    end
    check("fetch_grant_pattern", 32'(mask), 32'h210);

    drain(); tick();
    for (int i = 0; i < MAX_STALL; i++) begin
      if (!if_pend) req_if(rand_addr());
      req_d(1'b0, rand_addr(), '0);
      tick();
    end
    @(posedge clk); #2;
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0;
    #1;
    check("arst_if_rvalid", 32'(if_rvalid), 32'(0));
    check("arst_d_rvalid", 32'(d_rvalid), 32'(0));
    if_q.delete(); d_q.delete(); denied = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req_d(1'b0, rand_addr(), '0); tick();
    check("post_reset_data_wins", 32'(g_d), 32'(1));
    drain();

    for (int i = 0; i < 400; i++) begin
      if (!if_pend && ($urandom % 4) != 0) req_if(rand_addr());
      if (!d_pend && ($urandom % 4) != 0) req_d(1'($urandom % 2), rand_addr(), $urandom);
      tick();
    end
    drain();
    repeat (3) tick();
    check("if_q_drained", 32'(if_q.size()), 32'(0));
    check("d_q_drained", 32'(d_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
